scalar_ex_mem_reg: RTL and testbench



---
 rtl/scalar_pipe_pkg.sv | 48 ++++
 rtl/scalar_ex_mem_reg_skid_buffer.sv | 126 ++++++++++++
 rtl/scalar_ex_mem_reg.sv | 130 +++++++++++++
 tb/tb_scalar_ex_mem_reg.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_pipe_pkg.sv
// -----------------------------------------------------------------------------
// scalar_pipe_pkg
//   Shared types for the scalar execute -> memory pipeline boundary.
//   - EX_N / EX_RA_W : datapath and register-address widths of the payload.
//   - ex_mem_t       : payload carried from execute to memory.
//   - FLAG_*         : bit positions inside the 4-bit {N,Z,C,V} flag vector.
//   - buf_state_t    : occupancy state of the 2-entry skid buffer.
// -----------------------------------------------------------------------------
package scalar_pipe_pkg;

  localparam int EX_N    = 24;
  localparam int EX_RA_W = 4;

  // Flag vector layout is {N,Z,C,V}, MSB first.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [EX_N-1:0]    result;
    logic [EX_N-1:0]    store_data;
    logic [EX_RA_W-1:0] rd;
    logic               reg_write;
    logic               mem_write;
    logic               mem_to_reg;
  } ex_mem_t;

  // EMPTY: nothing held. ONE: MAIN valid. TWO: MAIN and SKID valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // Convenience packer for the {N,Z,C,V} flag vector.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/scalar_ex_mem_reg_skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//   Generic 2-entry valid/ready buffer. MAIN drives out_data; SKID catches the
//   one extra beat that may arrive while the consumer stalls. in_ready and
//   out_valid are both flops, so there is no combinational path from
//   out_ready to in_ready.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
//   high. Upstream (in_*) may not rely on in_ready changing within a cycle;
//   downstream sees out_data held bit-stable while out_valid=1 and
//   out_ready=0. flush empties the buffer and drops the incoming beat.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard held and incoming beats
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   state             current occupancy (debug observation)
// -----------------------------------------------------------------------------
module skid_buffer
  import scalar_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output buf_state_t   state
);

  buf_state_t   state_q;
  buf_state_t   state_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         accept;
  logic         pop;
  logic         load_main_in;
  logic         load_main_skid;
  logic         load_skid;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = out_valid_q & out_ready;

  // State register. in_ready/out_valid are registered decodes of the next
  // state so they are available at the start of every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !pop)      state_d = TWO;
          else if (pop && !accept) state_d = EMPTY;
          else                     state_d = ONE;
        end
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output / datapath-control logic. accept already excludes flush, so the
  // load strobes need no further gating; a MAIN<=SKID move on a flushed pop
  // is harmless because out_valid drops anyway.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: load_main_in = accept;
      ONE: begin
        load_main_in = accept & pop;
        load_skid    = accept & ~pop;
      end
      TWO:     load_main_skid = pop;
      default: ;
    endcase
  end

  // MAIN is reset so the outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  // SKID is only ever read after it has been loaded, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign state     = state_q;

endmodule

// File: rtl/scalar_ex_mem_reg.sv
// -----------------------------------------------------------------------------
// scalar_ex_mem_reg
//   Execute -> memory pipeline register. Captures the ALU result, store data
//   and writeback/memory controls into a 2-entry skid buffer and presents them
//   to the memory stage. Also owns the architectural NZCV flag register,
//   updated when a set_flags instruction is accepted (program order), not
//   when it leaves the stage.
//
// Handshake: in_valid/in_ready and out_valid/out_ready transfer on a rising
//   edge with both high; in_ready is a flop; out_* hold steady while stalled.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid, in_ready          execute-side handshake
//   in_result, in_flags, in_store_data, in_rd,
//   in_reg_write, in_mem_write, in_mem_to_reg, in_set_flags  instruction
//   flush                       drop buffered and incoming instructions
//   out_valid, out_ready        memory-side handshake
//   out_result, out_store_data, out_rd,
//   out_reg_write, out_mem_write, out_mem_to_reg             instruction
//   flags_q                     architectural {N,Z,C,V}
//   dbg_state                   skid-buffer occupancy (debug)
//   stall_cnt                   saturating count of stalled cycles, present
//                               only when SCALAR_EX_STALL_CNT_EN is defined
//
// N and RA_W must match EX_N / EX_RA_W of scalar_pipe_pkg (payload struct).
// -----------------------------------------------------------------------------
module scalar_ex_mem_reg
  import scalar_pipe_pkg::*;
#(
  parameter int N    = EX_N,
  parameter int RA_W = EX_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_result,
  input  logic [3:0]      in_flags,
  input  logic [N-1:0]    in_store_data,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_write,
  input  logic            in_mem_to_reg,
  input  logic            in_set_flags,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic [N-1:0]    out_store_data,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic [3:0]      flags_q,
  output buf_state_t      dbg_state
`ifdef SCALAR_EX_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  ex_mem_t    in_pkt;
  ex_mem_t    out_pkt;
  logic       accept;
  logic [3:0] flags_r;

  always_comb begin
    in_pkt            = '0;
    in_pkt.result     = in_result;
    in_pkt.store_data = in_store_data;
    in_pkt.rd         = in_rd;
    in_pkt.reg_write  = in_reg_write;
    in_pkt.mem_write  = in_mem_write;
    in_pkt.mem_to_reg = in_mem_to_reg;
  end

  skid_buffer #(
    .W($bits(ex_mem_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pkt),
    .state     (dbg_state)
  );

  assign out_result     = out_pkt.result;
  assign out_store_data = out_pkt.store_data;
  assign out_rd         = out_pkt.rd;
  assign out_reg_write  = out_pkt.reg_write;
  assign out_mem_write  = out_pkt.mem_write;
  assign out_mem_to_reg = out_pkt.mem_to_reg;

  // Same acceptance condition the buffer uses; flags follow acceptance so a
  // younger instruction in execute already sees the older one's flags.
  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 4'b0000;
    end else if (accept && in_set_flags) begin
      flags_r <= in_flags;
    end
  end

  assign flags_q = flags_r;

`ifdef SCALAR_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Counts cycles the memory stage refuses a valid entry; saturates, and
  // survives flush so it reflects the whole run since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid && !out_ready && stall_cnt_r != 16'hFFFF) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_scalar_ex_mem_reg.sv
module tb_scalar_ex_mem_reg;
  import scalar_pipe_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_result;
  logic [3:0]  in_flags;
  logic [23:0] in_store_data;
  logic [3:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_write;
  logic        in_mem_to_reg;
  logic        in_set_flags;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_result;
  logic [23:0] out_store_data;
  logic [3:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_write;
  logic        out_mem_to_reg;
  logic [3:0]  flags_q;
  buf_state_t  dbg_state;
`ifdef SCALAR_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [23:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  scalar_ex_mem_reg #(.N(24), .RA_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_flags       (in_flags),
    .in_store_data  (in_store_data),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_write   (in_mem_write),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_set_flags   (in_set_flags),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_write  (out_mem_write),
    .out_mem_to_reg (out_mem_to_reg),
    .flags_q        (flags_q),
    .dbg_state      (dbg_state)
`ifdef SCALAR_EX_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_result     = '0;
    in_flags      = '0;
    in_store_data = '0;
    in_rd         = '0;
    in_reg_write  = 1'b0;
    in_mem_write  = 1'b0;
    in_mem_to_reg = 1'b0;
    in_set_flags  = 1'b0;
    flush         = 1'b0;
  endtask

  // ctrl = {reg_write, mem_write, mem_to_reg}
  task automatic drive_op(input logic [23:0] result, input logic [23:0] sdata,
                          input logic [3:0] rd, input logic [2:0] ctrl,
                          input logic sf, input logic [3:0] fl);
    in_valid      = 1'b1;
    in_result     = result;
    in_store_data = sdata;
    in_rd         = rd;
    in_reg_write  = ctrl[2];
    in_mem_write  = ctrl[1];
    in_mem_to_reg = ctrl[0];
    in_set_flags  = sf;
    in_flags      = fl;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    step();
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (flags_q !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags_q);
    else pass_cnt++;
    total_cnt++;
    if ({out_result, out_store_data, out_rd} !== 52'd0)
      $display("FAIL reset_out_data got=%h/%h/%h exp=0", out_result, out_store_data, out_rd);
    else pass_cnt++;
    total_cnt++;
    if ({out_reg_write, out_mem_write, out_mem_to_reg} !== 3'b000)
      $display("FAIL reset_out_ctrl got=%b%b%b exp=000", out_reg_write, out_mem_write, out_mem_to_reg);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== EMPTY) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, EMPTY);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_op(24'h00002A, 24'h5A5A00, 4'd3, 3'b100, 1'b0, 4'b0000);
    step();
    idle_inputs();
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_result !== 24'h00002A || out_store_data !== 24'h5A5A00 || out_rd !== 4'd3)
      $display("FAIL single_data got=%h/%h/%0d exp=00002a/5a5a00/3", out_result, out_store_data, out_rd);
    else pass_cnt++;
    total_cnt++;
    if ({out_reg_write, out_mem_write, out_mem_to_reg} !== 3'b100)
      $display("FAIL single_ctrl got=%b%b%b exp=100", out_reg_write, out_mem_write, out_mem_to_reg);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive_op(24'h000001, 24'h000011, 4'd1, 3'b100, 1'b0, 4'b0000);
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 24'h000001)
      $display("FAIL bp_first got rdy=%b v=%b r=%h exp rdy=1 v=1 r=000001", in_ready, out_valid, out_result);
    else pass_cnt++;
    drive_op(24'h000002, 24'h000022, 4'd2, 3'b010, 1'b0, 4'b0000);
    step();
    total_cnt++;
    if (in_ready !== 1'b0 || out_result !== 24'h000001)
      $display("FAIL bp_full got rdy=%b r=%h exp rdy=0 r=000001", in_ready, out_result);
    else pass_cnt++;
    // Third push must be refused; outputs held across two stalled cycles.
    drive_op(24'h000003, 24'h000033, 4'd5, 3'b001, 1'b0, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || out_result !== 24'h000001 || out_store_data !== 24'h000011 ||
          out_rd !== 4'd1 || {out_reg_write, out_mem_write, out_mem_to_reg} !== 3'b100 || in_ready !== 1'b0)
        $display("FAIL bp_stable cyc=%0d got v=%b r=%h sd=%h rd=%0d rdy=%b exp v=1 r=000001 sd=000011 rd=1 rdy=0",
                 k, out_valid, out_result, out_store_data, out_rd, in_ready);
      else pass_cnt++;
    end
    idle_inputs();
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || out_result !== 24'h000002 || out_rd !== 4'd2 ||
        out_mem_write !== 1'b1 || out_store_data !== 24'h000022 || in_ready !== 1'b1)
      $display("FAIL bp_second got v=%b r=%h rd=%0d mw=%b rdy=%b exp v=1 r=000002 rd=2 mw=1 rdy=1",
               out_valid, out_result, out_rd, out_mem_write, in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_third got=%b exp=0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive_op(24'h000010, 24'h0, 4'd1, 3'b100, 1'b1, 4'b0100);
    step();
    total_cnt++;
    if (flags_q !== 4'b0100) $display("FAIL flags_set1 got=%b exp=0100", flags_q);
    else pass_cnt++;
    drive_op(24'h000011, 24'h0, 4'd2, 3'b100, 1'b0, 4'b1001);
    step();
    total_cnt++;
    if (flags_q !== 4'b0100) $display("FAIL flags_noset got=%b exp=0100", flags_q);
    else pass_cnt++;
    drive_op(24'h000012, 24'h0, 4'd3, 3'b100, 1'b1, 4'b1000);
    step();
    total_cnt++;
    if (flags_q !== 4'b1000) $display("FAIL flags_set2 got=%b exp=1000", flags_q);
    else pass_cnt++;
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_op(24'h0000AA, 24'h0, 4'd7, 3'b100, 1'b0, 4'b0000);
    step();
    drive_op(24'h0000BB, 24'h0, 4'd8, 3'b100, 1'b0, 4'b0000);
    step();
    total_cnt++;
    if (in_ready !== 1'b0 || dbg_state !== TWO)
      $display("FAIL flush_fill got rdy=%b st=%0d exp rdy=0 st=%0d", in_ready, dbg_state, TWO);
    else pass_cnt++;
    // Refused set_flags op must not touch flags_q.
    drive_op(24'h0000CC, 24'h0, 4'd9, 3'b100, 1'b1, 4'b0011);
    step();
    total_cnt++;
    if (flags_q !== 4'b1000) $display("FAIL flags_rejected got=%b exp=1000", flags_q);
    else pass_cnt++;
    flush = 1'b1;
    step();
    idle_inputs();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags_q !== 4'b1000 || dbg_state !== EMPTY)
      $display("FAIL flush_state got v=%b rdy=%b fl=%b st=%0d exp v=0 rdy=1 fl=1000 st=0",
               out_valid, in_ready, flags_q, dbg_state);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL flush_ghost cyc=%0d got v=%b r=%h exp v=0", k, out_valid, out_result);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int popped;
    int ready_low;
    logic [23:0] exp_v;
    popped    = 0;
    ready_low = 0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_op(24'(i + 256), 24'(i * 3), 4'(i), 3'b100, 1'b0, 4'b0000);
      if (in_ready === 1'b1) exp_q.push_back(24'(i + 256));
      else ready_low++;
      step();
      if (out_valid === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra got r=%h exp none", out_result);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_result !== exp_v) $display("FAIL stream_data idx=%0d got=%h exp=%h", popped, out_result, exp_v);
          else pass_cnt++;
        end
        popped++;
      end
    end
    idle_inputs();
    step();
    total_cnt++;
    if (popped != 100 || exp_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL stream_count got pops=%0d left=%0d v=%b exp pops=100 left=0 v=0", popped, exp_q.size(), out_valid);
    else pass_cnt++;
    total_cnt++;
    if (ready_low != 0) $display("FAIL stream_ready got low_cycles=%0d exp=0", ready_low);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_op(24'h000077, 24'h0, 4'd4, 3'b100, 1'b1, 4'b0110);
    step();
    total_cnt++;
    if (flags_q !== 4'b0110) $display("FAIL mid_flags got=%b exp=0110", flags_q);
    else pass_cnt++;
    drive_op(24'h000078, 24'h0, 4'd5, 3'b100, 1'b0, 4'b0000);
    step();
    rst   = 1'b1;
    flush = 1'b1;
    drive_op(24'h000079, 24'h0, 4'd6, 3'b100, 1'b1, 4'b1111);
    step();
    rst = 1'b0;
    idle_inputs();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags_q !== 4'b0000 || out_result !== 24'h0)
      $display("FAIL mid_reset got v=%b rdy=%b fl=%b r=%h exp v=0 rdy=1 fl=0000 r=000000",
               out_valid, in_ready, flags_q, out_result);
    else pass_cnt++;
  endtask

`ifdef SCALAR_EX_STALL_CNT_EN
  task automatic test_stall_cnt();
    total_cnt++;
    if (stall_cnt !== 16'd0) $display("FAIL stall_reset got=%0d exp=0", stall_cnt);
    else pass_cnt++;
    out_ready = 1'b0;
    drive_op(24'h000055, 24'h0, 4'd1, 3'b100, 1'b0, 4'b0000);
    step();
    idle_inputs();
    repeat (5) step();
    total_cnt++;
    if (stall_cnt !== 16'd5) $display("FAIL stall_five got=%0d exp=5", stall_cnt);
    else pass_cnt++;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    step();
    total_cnt++;
    if (stall_cnt !== 16'd5) $display("FAIL stall_flush got=%0d exp=5", stall_cnt);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (stall_cnt !== 16'd0) $display("FAIL stall_clear got=%0d exp=0", stall_cnt);
    else pass_cnt++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_pressure();
    test_flags();
    test_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef SCALAR_EX_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
